// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state and source-port encodings.
package mem_responder_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        MR_STATE_IDLE = 2'd0,
        MR_STATE_WAIT = 2'd1,
        MR_STATE_RESP = 2'd2
    } mr_state_t;

    // Identifies which port owns the outstanding transaction.
    typedef enum logic [1:0] {
        MR_PORT_INST   = 2'd0,
        MR_PORT_DREAD  = 2'd1,
        MR_PORT_DWRITE = 2'd2
    } mr_port_t;

endpackage

// File: rtl/sp_ram.sv
// Word-organised single-port RAM with per-byte write enables and a registered read.
// Contents are never reset; the read register only updates when re is high so it
// can hold a read result for the whole response latency.
module sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [DATA_WIDTH/8-1:0]        strobe,
    input  logic                           re,
    input  logic [$clog2(MEM_DEPTH)-1:0]   index,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic [DATA_WIDTH-1:0]          rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-masked write into the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strobe[b]) begin
                    mem_r[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read, held between read enables.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: fixed-priority arbiter over write / data-read / instruction-read
// ports, one outstanding access, response pulse LATENCY cycles after accept.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ir_addr_valid,
    input  logic [ADDR_WIDTH-1:0]   ir_addr,
    output logic                    ir_addr_ready,
    output logic                    ir_data_valid,
    output logic [DATA_WIDTH-1:0]   ir_data,
    input  logic                    dr_addr_valid,
    input  logic [ADDR_WIDTH-1:0]   dr_addr,
    output logic                    dr_addr_ready,
    output logic                    dr_data_valid,
    output logic [DATA_WIDTH-1:0]   dr_data,
    input  logic                    dw_valid,
    input  logic [ADDR_WIDTH-1:0]   dw_addr,
    input  logic [DATA_WIDTH-1:0]   dw_data,
    input  logic [DATA_WIDTH/8-1:0] dw_strobe,
    output logic                    dw_ready,
    output logic                    dw_resp_valid
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mr_state_t           state_r;
    mr_port_t            port_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                ir_valid_r;
    logic                dr_valid_r;
    logic                dw_valid_r;

    logic                idle_s;
    logic                ir_grant_s;
    logic                dr_grant_s;
    logic                dw_grant_s;
    logic                accept_s;
    logic [IDX_W-1:0]    index_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // Address bits outside the word index do not take part in the access.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{ir_addr[ADDR_WIDTH-1:IDX_W+2], ir_addr[1:0],
                                  dr_addr[ADDR_WIDTH-1:IDX_W+2], dr_addr[1:0],
                                  dw_addr[ADDR_WIDTH-1:IDX_W+2], dw_addr[1:0]};

    assign idle_s = (state_r == MR_STATE_IDLE) && !rst;

    // Fixed-priority grant in IDLE: write, then data read, then instruction read.
    always_comb begin
        dw_grant_s = 1'b0;
        dr_grant_s = 1'b0;
        ir_grant_s = 1'b0;
        if (idle_s) begin
            if (dw_valid) begin
                dw_grant_s = 1'b1;
            end else if (dr_addr_valid) begin
                dr_grant_s = 1'b1;
            end else if (ir_addr_valid) begin
                ir_grant_s = 1'b1;
            end else begin
                ir_grant_s = 1'b0;
            end
        end else begin
            dw_grant_s = 1'b0;
        end
    end

    assign accept_s      = dw_grant_s | dr_grant_s | ir_grant_s;
    assign dw_ready      = dw_grant_s;
    assign dr_addr_ready = dr_grant_s;
    assign ir_addr_ready = ir_grant_s;

    // RAM word index taken from the winning port's address.
    always_comb begin
        index_s = ir_addr[IDX_W+1:2];
        if (dw_grant_s) begin
            index_s = dw_addr[IDX_W+1:2];
        end else if (dr_grant_s) begin
            index_s = dr_addr[IDX_W+1:2];
        end else begin
            index_s = ir_addr[IDX_W+1:2];
        end
    end

    // The RAM read register doubles as the response data register.
    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (dw_grant_s),
        .strobe (dw_strobe),
        .re     (dr_grant_s | ir_grant_s),
        .index  (index_s),
        .wdata  (dw_data),
        .rdata  (ram_rdata_s)
    );

    // Responder FSM: latency counter, latched source port and registered response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= MR_STATE_IDLE;
            port_r     <= MR_PORT_INST;
            cnt_r      <= {CNT_W{1'b0}};
            ir_valid_r <= 1'b0;
            dr_valid_r <= 1'b0;
            dw_valid_r <= 1'b0;
        end else begin
            case (state_r)
                MR_STATE_IDLE: begin
                    ir_valid_r <= 1'b0;
                    dr_valid_r <= 1'b0;
                    dw_valid_r <= 1'b0;
                    if (accept_s) begin
                        port_r <= dw_grant_s ? MR_PORT_DWRITE :
                                  dr_grant_s ? MR_PORT_DREAD  : MR_PORT_INST;
                        if (LATENCY == 1) begin
                            state_r    <= MR_STATE_RESP;
                            ir_valid_r <= ir_grant_s;
                            dr_valid_r <= dr_grant_s;
                            dw_valid_r <= dw_grant_s;
                        end else begin
                            state_r <= MR_STATE_WAIT;
                            cnt_r   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                MR_STATE_WAIT: begin
                    if (cnt_r == CNT_W'(1)) begin
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= MR_STATE_RESP;
                        ir_valid_r <= (port_r == MR_PORT_INST);
                        dr_valid_r <= (port_r == MR_PORT_DREAD);
                        dw_valid_r <= (port_r == MR_PORT_DWRITE);
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                MR_STATE_RESP: begin
                    state_r    <= MR_STATE_IDLE;
                    ir_valid_r <= 1'b0;
                    dr_valid_r <= 1'b0;
                    dw_valid_r <= 1'b0;
                end
                default: begin
                    state_r    <= MR_STATE_IDLE;
                    cnt_r      <= {CNT_W{1'b0}};
                    ir_valid_r <= 1'b0;
                    dr_valid_r <= 1'b0;
                    dw_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ir_data_valid = ir_valid_r;
    assign dr_data_valid = dr_valid_r;
    assign dw_resp_valid = dw_valid_r;
    // Read data is forced to zero outside the owning port's response cycle.
    assign ir_data = ir_valid_r ? ram_rdata_s : {DATA_WIDTH{1'b0}};
    assign dr_data = dr_valid_r ? ram_rdata_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model with per-byte validity.
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_addr_valid, ir_addr_ready, ir_data_valid;
    logic [31:0] ir_addr, ir_data;
    logic        dr_addr_valid, dr_addr_ready, dr_data_valid;
    logic [31:0] dr_addr, dr_data;
    logic        dw_valid, dw_ready, dw_resp_valid;
    logic [31:0] dw_addr, dw_data;
    logic [3:0]  dw_strobe;

    logic        l1_ir_addr_valid, l1_ir_addr_ready, l1_ir_data_valid;
    logic [31:0] l1_ir_addr, l1_ir_data;
    logic        l1_dr_addr_valid, l1_dr_addr_ready, l1_dr_data_valid;
    logic [31:0] l1_dr_addr, l1_dr_data;
    logic        l1_dw_valid, l1_dw_ready, l1_dw_resp_valid;
    logic [31:0] l1_dw_addr, l1_dw_data;
    logic [3:0]  l1_dw_strobe;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [31:0] model_word [int];
    logic [3:0]  model_mask [int];
    int          written_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr(ir_addr), .ir_addr_ready(ir_addr_ready),
        .ir_data_valid(ir_data_valid), .ir_data(ir_data),
        .dr_addr_valid(dr_addr_valid), .dr_addr(dr_addr), .dr_addr_ready(dr_addr_ready),
        .dr_data_valid(dr_data_valid), .dr_data(dr_data),
        .dw_valid(dw_valid), .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
        .dw_ready(dw_ready), .dw_resp_valid(dw_resp_valid));

    mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .ir_addr_valid(l1_ir_addr_valid), .ir_addr(l1_ir_addr), .ir_addr_ready(l1_ir_addr_ready),
        .ir_data_valid(l1_ir_data_valid), .ir_data(l1_ir_data),
        .dr_addr_valid(l1_dr_addr_valid), .dr_addr(l1_dr_addr), .dr_addr_ready(l1_dr_addr_ready),
        .dr_data_valid(l1_dr_data_valid), .dr_data(l1_dr_data),
        .dw_valid(l1_dw_valid), .dw_addr(l1_dw_addr), .dw_data(l1_dw_data), .dw_strobe(l1_dw_strobe),
        .dw_ready(l1_dw_ready), .dw_resp_valid(l1_dw_resp_valid));

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'd1023);
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        logic [31:0] w;
        logic [3:0] m;
        i = widx(a);
        w = model_word.exists(i) ? model_word[i] : 32'h0;
        m = model_mask.exists(i) ? model_mask[i] : 4'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                w[b*8 +: 8] = d[b*8 +: 8];
                m[b] = 1'b1;
            end
        end
        if (!model_mask.exists(i) && m != 4'h0) written_q.push_back(i);
        model_word[i] = w;
        model_mask[i] = m;
    endtask

    // kind: 0 = instruction read, 1 = data read, 2 = write. lat = -1 on timeout.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int lat, output logic [31:0] rdata,
                           output logic [31:0] other, output logic [2:0] pulses, output bit stray);
        int acc_cyc;
        bit got;
        acc_cyc = -1; got = 1'b0; lat = -1; rdata = 32'h0; other = 32'h0; pulses = 3'b000; stray = 1'b0;
        @(negedge clk);
        if (kind == 2) begin
            dw_valid = 1'b1; dw_addr = addr; dw_data = wdata; dw_strobe = strb;
        end else if (kind == 1) begin
            dr_addr_valid = 1'b1; dr_addr = addr;
        end else begin
            ir_addr_valid = 1'b1; ir_addr = addr;
        end
        for (int i = 0; i < 40 && acc_cyc < 0; i++) begin
            #1;
            if ((kind == 2 && dw_ready) || (kind == 1 && dr_addr_ready) || (kind == 0 && ir_addr_ready))
                acc_cyc = cyc;
            else
                @(negedge clk);
        end
        @(negedge clk);
        dw_valid = 1'b0; dr_addr_valid = 1'b0; ir_addr_valid = 1'b0;
        if (acc_cyc < 0) return;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (ir_data_valid || dr_data_valid || dw_resp_valid) begin
                got = 1'b1;
                lat = cyc - acc_cyc;
                pulses = {dw_resp_valid, dr_data_valid, ir_data_valid};
                rdata = (kind == 0) ? ir_data : ((kind == 1) ? dr_data : 32'h0);
                other = (kind == 0) ? dr_data : ((kind == 1) ? ir_data : (ir_data | dr_data));
            end else begin
                if (ir_data !== 32'h0 || dr_data !== 32'h0) stray = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ir_addr_valid = 1'b1; dr_addr_valid = 1'b1; dw_valid = 1'b1;
        ir_addr = 32'h40; dr_addr = 32'h44; dw_addr = 32'h48; dw_data = 32'h0; dw_strobe = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ir_addr_ready, dr_addr_ready, dw_ready, ir_data_valid, dr_data_valid, dw_resp_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {ir_addr_ready, dr_addr_ready, dw_ready, ir_data_valid, dr_data_valid, dw_resp_valid});
        end
        checks++;
        if ({ir_data, dr_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h, want 0 0", ir_data, dr_data);
        end
        @(negedge clk);
        ir_addr_valid = 1'b0; dr_addr_valid = 1'b0; dw_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({ir_data_valid, dr_data_valid, dw_resp_valid, l1_ir_data_valid} !== 4'b0 || {ir_data, dr_data} !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_idle: valids %b data %h %h, want all 0",
                     {ir_data_valid, dr_data_valid, dw_resp_valid, l1_ir_data_valid}, ir_data, dr_data);
        end
    endtask

    task automatic test_write_then_fetch;
        int lat; logic [31:0] rd, oth; logic [2:0] p; bit st;
        run_txn(2, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, oth, p, st);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (lat !== LAT || p !== 3'b100) begin
            errors++;
            $display("FAIL wr_resp: lat %0d pulses %b, want %0d 100", lat, p, LAT);
        end
        run_txn(0, 32'h10, 32'h0, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (lat !== LAT || p !== 3'b001) begin
            errors++;
            $display("FAIL fetch_resp: lat %0d pulses %b, want %0d 001", lat, p, LAT);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || oth !== 32'h0) begin
            errors++;
            $display("FAIL fetch_data: got %h (dr %h), want deadbeef (dr 0)", rd, oth);
        end
    endtask

    task automatic test_strobe;
        int lat; logic [31:0] rd, oth; logic [2:0] p; bit st;
        run_txn(2, 32'h20, 32'h11223344, 4'hF, lat, rd, oth, p, st);
        model_write(32'h20, 32'h11223344, 4'hF);
        run_txn(2, 32'h20, 32'hAABBCCDD, 4'h5, lat, rd, oth, p, st);
        model_write(32'h20, 32'hAABBCCDD, 4'h5);
        run_txn(1, 32'h20, 32'h0, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (lat !== LAT || p !== 3'b010 || rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe5: lat %0d pulses %b data %h, want %0d 010 11bb33dd", lat, p, rd, LAT);
        end
        run_txn(2, 32'h20, 32'hFFFFFFFF, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (lat !== LAT || p !== 3'b100) begin
            errors++;
            $display("FAIL strobe0_resp: lat %0d pulses %b, want %0d 100", lat, p, LAT);
        end
        run_txn(1, 32'h20, 32'h0, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe0_data: got %h, want 11bb33dd", rd);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd, oth; logic [2:0] p; bit st;
        run_txn(2, 32'h1000, 32'h5A5A1234, 4'hF, lat, rd, oth, p, st);
        model_write(32'h1000, 32'h5A5A1234, 4'hF);
        run_txn(1, 32'h3, 32'h0, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (lat !== LAT || rd !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL wrap_read: lat %0d data %h, want %0d 5a5a1234", lat, rd, LAT);
        end
    endtask

    task automatic test_priority;
        int acc [3]; int pc [3]; int pn [3];
        logic [31:0] pd [3];
        bit multi;
        for (int k = 0; k < 3; k++) begin acc[k] = -1; pc[k] = -1; pn[k] = 0; pd[k] = 32'h0; end
        multi = 1'b0;
        @(negedge clk);
        dw_valid = 1'b1; dw_addr = 32'h30; dw_data = 32'hCAFE0001; dw_strobe = 4'hF;
        dr_addr_valid = 1'b1; dr_addr = 32'h10;
        ir_addr_valid = 1'b1; ir_addr = 32'h20;
        model_write(32'h30, 32'hCAFE0001, 4'hF);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ($countones({ir_addr_ready, dr_addr_ready, dw_ready}) > 1) multi = 1'b1;
            if ($countones({ir_data_valid, dr_data_valid, dw_resp_valid}) > 1) multi = 1'b1;
            if (dw_ready) acc[2] = cyc;
            if (dr_addr_ready) acc[1] = cyc;
            if (ir_addr_ready) acc[0] = cyc;
            if (dw_resp_valid) begin pc[2] = cyc; pn[2]++; end
            if (dr_data_valid) begin pc[1] = cyc; pn[1]++; pd[1] = dr_data; end
            if (ir_data_valid) begin pc[0] = cyc; pn[0]++; pd[0] = ir_data; end
            @(negedge clk);
            if (acc[2] >= 0) dw_valid = 1'b0;
            if (acc[1] >= 0) dr_addr_valid = 1'b0;
            if (acc[0] >= 0) ir_addr_valid = 1'b0;
        end
        dw_valid = 1'b0; dr_addr_valid = 1'b0; ir_addr_valid = 1'b0;
        checks++;
        if (acc[2] < 0 || acc[1] - acc[2] != LAT + 1 || acc[0] - acc[1] != LAT + 1) begin
            errors++;
            $display("FAIL prio_order: accepts w=%0d dr=%0d ir=%0d, want spacing %0d in that order",
                     acc[2], acc[1], acc[0], LAT + 1);
        end
        checks++;
        if (multi || pn[0] != 1 || pn[1] != 1 || pn[2] != 1) begin
            errors++;
            $display("FAIL prio_onehot: overlap=%0d pulses ir=%0d dr=%0d w=%0d, want 0 1 1 1",
                     multi, pn[0], pn[1], pn[2]);
        end
        checks++;
        if (pc[2] - acc[2] != LAT || pc[1] - acc[1] != LAT || pc[0] - acc[0] != LAT) begin
            errors++;
            $display("FAIL prio_latency: w=%0d dr=%0d ir=%0d, want %0d each",
                     pc[2] - acc[2], pc[1] - acc[1], pc[0] - acc[0], LAT);
        end
        checks++;
        if (pd[1] !== model_word[widx(32'h10)] || pd[0] !== model_word[widx(32'h20)]) begin
            errors++;
            $display("FAIL prio_data: dr %h ir %h, want %h %h", pd[1], pd[0],
                     model_word[widx(32'h10)], model_word[widx(32'h20)]);
        end
    endtask

    task automatic test_reset_in_wait;
        int lat; int npulse; logic [31:0] rd, oth; logic [2:0] p; bit st;
        npulse = 0;
        @(negedge clk);
        dr_addr_valid = 1'b1; dr_addr = 32'h10;
        #1;
        checks++;
        if (dr_addr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_accept: ready %b, want 1", dr_addr_ready);
        end
        @(negedge clk);
        dr_addr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ir_data_valid, dr_data_valid, dw_resp_valid} !== 3'b0 || {ir_data, dr_data} !== 64'h0) begin
            errors++;
            $display("FAIL rstwait_clear: valids %b data %h %h, want 0",
                     {ir_data_valid, dr_data_valid, dw_resp_valid}, ir_data, dr_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (ir_data_valid || dr_data_valid || dw_resp_valid) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            errors++;
            $display("FAIL rstwait_dropped: %0d pulses seen, want 0", npulse);
        end
        run_txn(1, 32'h10, 32'h0, 4'h0, lat, rd, oth, p, st);
        checks++;
        if (lat !== LAT || p !== 3'b010 || rd !== model_word[widx(32'h10)]) begin
            errors++;
            $display("FAIL rstwait_next: lat %0d pulses %b data %h, want %0d 010 %h",
                     lat, p, rd, LAT, model_word[widx(32'h10)]);
        end
    endtask

    task automatic test_latency1;
        int acc_q [$]; int pls_q [$];
        int bad_ready; int bad_other; int bad_spacing;
        bad_ready = 0; bad_other = 0; bad_spacing = 0;
        @(negedge clk);
        l1_ir_addr_valid = 1'b1; l1_ir_addr = $urandom;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (l1_ir_data_valid) begin
                pls_q.push_back(cyc);
                if (l1_ir_addr_ready !== 1'b0) bad_ready++;
            end
            if (l1_dr_data_valid || l1_dw_resp_valid) bad_other++;
            if (l1_ir_addr_ready) acc_q.push_back(cyc);
            @(negedge clk);
            if (acc_q.size() > 0 && acc_q[$] == cyc - 1) l1_ir_addr = $urandom;
        end
        l1_ir_addr_valid = 1'b0;
        checks++;
        if (pls_q.size() != 12 || acc_q.size() != 12) begin
            errors++;
            $display("FAIL lat1_count: pulses %0d accepts %0d, want 12 12", pls_q.size(), acc_q.size());
        end
        for (int k = 0; k < pls_q.size() && k < acc_q.size(); k++) begin
            if (pls_q[k] - acc_q[k] != 1) bad_spacing++;
            if (k > 0 && pls_q[k] - pls_q[k-1] != 2) bad_spacing++;
        end
        checks++;
        if (bad_spacing != 0 || bad_ready != 0 || bad_other != 0) begin
            errors++;
            $display("FAIL lat1_timing: spacing errs %0d ready-in-resp %0d wrong-port %0d, want 0 0 0",
                     bad_spacing, bad_ready, bad_other);
        end
    endtask

    task automatic test_random;
        int lat; int kind; int idx; logic [31:0] rd, oth, a, d, m32; logic [3:0] s; logic [2:0] p; bit st;
        for (int n = 0; n < 40; n++) begin
            kind = (written_q.size() == 0) ? 2 : int'($urandom_range(0, 2));
            if (kind == 2) begin
                a = $urandom; d = $urandom; s = 4'($urandom_range(0, 15));
                run_txn(2, a, d, s, lat, rd, oth, p, st);
                model_write(a, d, s);
                checks++;
                if (lat !== LAT || p !== 3'b100 || oth !== 32'h0) begin
                    errors++;
                    $display("FAIL rnd_write[%0d]: lat %0d pulses %b data %h, want %0d 100 0", n, lat, p, oth, LAT);
                end
            end else begin
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                a = ($urandom & 32'hFFFFF003) | (32'(idx) << 2);
                run_txn(kind, a, 32'h0, 4'h0, lat, rd, oth, p, st);
                m32 = expand(model_mask[idx]);
                checks++;
                if (lat !== LAT || p !== ((kind == 1) ? 3'b010 : 3'b001) || oth !== 32'h0 || st) begin
                    errors++;
                    $display("FAIL rnd_read_ctl[%0d]: kind %0d lat %0d pulses %b other %h stray %0d", n, kind, lat, p, oth, st);
                end
                checks++;
                if ((rd & m32) !== (model_word[idx] & m32)) begin
                    errors++;
                    $display("FAIL rnd_read_data[%0d]: addr %h got %h, want %h (mask %h)",
                             n, a, rd & m32, model_word[idx] & m32, m32);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        ir_addr_valid = 1'b0; ir_addr = 32'h0; dr_addr_valid = 1'b0; dr_addr = 32'h0;
        dw_valid = 1'b0; dw_addr = 32'h0; dw_data = 32'h0; dw_strobe = 4'h0;
        l1_ir_addr_valid = 1'b0; l1_ir_addr = 32'h0; l1_dr_addr_valid = 1'b0; l1_dr_addr = 32'h0;
        l1_dw_valid = 1'b0; l1_dw_addr = 32'h0; l1_dw_data = 32'h0; l1_dw_strobe = 4'h0;
        test_reset();
        test_write_then_fetch();
        test_strobe();
        test_wrap();
        test_priority();
        test_reset_in_wait();
        test_latency1();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
